// File: rtl/iq_deserializer_pkg.sv
// iq_deserializer_pkg: frame constants and FSM state encoding shared by the I/Q deserializer
package iq_deserializer_pkg;

    localparam logic [1:0] IQ_I_SYNC = 2'b10;
    localparam logic [1:0] IQ_Q_SYNC = 2'b01;

    function automatic int iq_frame_len(input int iq_width);
        return 2 * (iq_width + 2);
    endfunction

    localparam int IQ_FRAME_LEN = iq_frame_len(14);

    typedef enum logic [1:0] {
        IQD_HUNT   = 2'd0,
        IQD_VERIFY = 2'd1,
        IQD_LOCKED = 2'd2
    } iqd_state_e;

endpackage

// File: rtl/iq_deserializer.sv
// iq_deserializer: recovers framed serial I/Q sample pairs, tracks frame lock and counts sync errors
module iq_deserializer
    import iq_deserializer_pkg::*;
#(
    parameter int IQ_WIDTH      = 14,
    parameter int LOCK_FRAMES   = 3,
    parameter int MISS_LIMIT    = 2,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     serial_in,
    output logic [IQ_WIDTH-1:0]      I,
    output logic [IQ_WIDTH-1:0]      Q,
    output logic                     sample_valid,
    output logic                     locked,
    output logic                     sync_err,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    localparam int FL = iq_frame_len(IQ_WIDTH);
    localparam int CW = $clog2(FL);
    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam int MW = $clog2(MISS_LIMIT + 1);

    iqd_state_e               state_q, state_d;
    logic [FL-2:0]            sr_q, sr_d;
    logic [FL-1:0]            sr_next;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [GW-1:0]            good_q, good_d;
    logic [MW-1:0]            miss_q, miss_d;
    logic [IQ_WIDTH-1:0]      i_q, i_d, q_q, q_d;
    logic                     sample_valid_q, sample_valid_d;
    logic                     locked_q, locked_d;
    logic                     sync_err_q, sync_err_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic                     match, boundary;

    // The oldest bit of a frame only lives in sr_next, so the register holds one bit less than a frame
    assign sr_next  = {sr_q, serial_in};
    assign match    = (sr_next[FL-1 -: 2] == IQ_I_SYNC) && (sr_next[IQ_WIDTH +: 2] == IQ_Q_SYNC);
    assign boundary = cnt_q == CW'(FL - 1);

    // Next-state logic: hunt for alignment, confirm it over several frames, then unpack frames while locked
    always_comb begin
        state_d        = state_q;
        sr_d           = sr_next[FL-2:0];
        cnt_d          = boundary ? '0 : cnt_q + CW'(1);
        good_d         = good_q;
        miss_d         = miss_q;
        i_d            = i_q;
        q_d            = q_q;
        sample_valid_d = 1'b0;
        sync_err_d     = 1'b0;
        locked_d       = locked_q;
        err_count_d    = err_count_q;
        if (!enable) begin
            state_d  = IQD_HUNT;
            sr_d     = '0;
            cnt_d    = '0;
            good_d   = '0;
            miss_d   = '0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                IQD_HUNT: begin
                    cnt_d = '0;
                    if (match) begin
                        good_d   = GW'(1);
                        state_d  = (LOCK_FRAMES == 1) ? IQD_LOCKED : IQD_VERIFY;
                        locked_d = (LOCK_FRAMES == 1);
                    end
                end
                IQD_VERIFY: begin
                    if (boundary && !match) begin
                        state_d = IQD_HUNT;
                        good_d  = '0;
                    end else if (boundary) begin
                        good_d = good_q + GW'(1);
                        if (good_q == GW'(LOCK_FRAMES - 1)) begin
                            state_d  = IQD_LOCKED;
                            locked_d = 1'b1;
                        end
                    end
                end
                IQD_LOCKED: begin
                    if (boundary && match) begin
                        i_d            = sr_next[FL-3 -: IQ_WIDTH];
                        q_d            = sr_next[IQ_WIDTH-1:0];
                        sample_valid_d = 1'b1;
                        miss_d         = '0;
                    end else if (boundary) begin
                        sync_err_d  = 1'b1;
                        err_count_d = (err_count_q == '1) ? err_count_q : err_count_q + ERR_CNT_WIDTH'(1);
                        miss_d      = miss_q + MW'(1);
                        if (miss_q == MW'(MISS_LIMIT - 1)) begin
                            state_d  = IQD_HUNT;
                            locked_d = 1'b0;
                            miss_d   = '0;
                            good_d   = '0;
                        end
                    end
                end
                default: state_d = IQD_HUNT;
            endcase
        end
    end

    // State and output registers, cleared asynchronously by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IQD_HUNT;
            sr_q           <= '0;
            cnt_q          <= '0;
            good_q         <= '0;
            miss_q         <= '0;
            i_q            <= '0;
            q_q            <= '0;
            sample_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            sync_err_q     <= 1'b0;
            err_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            sr_q           <= sr_d;
            cnt_q          <= cnt_d;
            good_q         <= good_d;
            miss_q         <= miss_d;
            i_q            <= i_d;
            q_q            <= q_d;
            sample_valid_q <= sample_valid_d;
            locked_q       <= locked_d;
            sync_err_q     <= sync_err_d;
            err_count_q    <= err_count_d;
        end
    end

    assign I            = i_q;
    assign Q            = q_q;
    assign sample_valid = sample_valid_q;
    assign locked       = locked_q;
    assign sync_err     = sync_err_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_iq_deserializer.sv
// tb_iq_deserializer: frame-table and scoreboard bench for iq_deserializer
module tb_iq_deserializer;
    import iq_deserializer_pkg::*;

    logic        clk, rst_n, enable, serial_in;
    logic [13:0] i_out, q_out, si_out, sq_out;
    logic        valid, lock, serr, s_valid, s_lock, s_serr;
    logic [7:0]  ecnt, s_ecnt;

    int errors = 0;
    int checks = 0;
    int err_pulses = 0;
    logic [27:0] sb[$];

    iq_deserializer dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .serial_in(serial_in),
        .I(i_out), .Q(q_out), .sample_valid(valid), .locked(lock),
        .sync_err(serr), .err_count(ecnt)
    );

    iq_deserializer #(.MISS_LIMIT(1000)) dut_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable), .serial_in(serial_in),
        .I(si_out), .Q(sq_out), .sample_valid(s_valid), .locked(s_lock),
        .sync_err(s_serr), .err_count(s_ecnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  is;
        logic [13:0] i;
        logic [1:0]  qs;
        logic [13:0] q;
        logic        ev, ee, el;
        logic [7:0]  ec;
        logic [13:0] ei, eq;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int b = 31; b > 31 - n; b--) send_bit(w[b]);
    endtask

    task automatic send_frame(input logic [1:0] is, input logic [13:0] i, input logic [1:0] qs, input logic [13:0] q);
        send_bits({is, i, qs, q}, IQ_FRAME_LEN);
    endtask

    task automatic chk_frame(input string tag, input logic ev, input logic ee, input logic el, input logic [7:0] ec);
        chk({tag, "_valid"}, 32'(valid), 32'(ev));
        chk({tag, "_sync_err"}, 32'(serr), 32'(ee));
        chk({tag, "_locked"}, 32'(lock), 32'(el));
        chk({tag, "_err_count"}, 32'(ecnt), 32'(ec));
    endtask

    // Scoreboard: every sample_valid must match the oldest expected I/Q pair
    always @(negedge clk) begin
        if (serr) err_pulses++;
        if (valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got I=%h Q=%h expected no sample", i_out, q_out);
            end else begin
                logic [27:0] e;
                e = sb.pop_front();
                chk("sb_I", 32'(i_out), 32'(e[27:14]));
                chk("sb_Q", 32'(q_out), 32'(e[13:0]));
            end
        end
    end

    initial begin
        int p0;
        vt[0]  = '{2'b10, 14'h0ABC, 2'b01, 14'h3F01, 1'b0, 1'b0, 1'b0, 8'd0, 14'h0000, 14'h0000};
        vt[1]  = '{2'b10, 14'h0ABC, 2'b01, 14'h3F01, 1'b0, 1'b0, 1'b0, 8'd0, 14'h0000, 14'h0000};
        vt[2]  = '{2'b10, 14'h0ABC, 2'b01, 14'h3F01, 1'b0, 1'b0, 1'b1, 8'd0, 14'h0000, 14'h0000};
        vt[3]  = '{2'b10, 14'h0ABC, 2'b01, 14'h3F01, 1'b1, 1'b0, 1'b1, 8'd0, 14'h0ABC, 14'h3F01};
        vt[4]  = '{2'b10, 14'h0ABC, 2'b01, 14'h3F01, 1'b1, 1'b0, 1'b1, 8'd0, 14'h0ABC, 14'h3F01};
        vt[5]  = '{2'b11, 14'h0ABC, 2'b01, 14'h3F01, 1'b0, 1'b1, 1'b1, 8'd1, 14'h0ABC, 14'h3F01};
        vt[6]  = '{2'b10, 14'h2000, 2'b01, 14'h1FFF, 1'b1, 1'b0, 1'b1, 8'd1, 14'h2000, 14'h1FFF};
        vt[7]  = '{2'b10, 14'h0000, 2'b00, 14'h0000, 1'b0, 1'b1, 1'b1, 8'd2, 14'h2000, 14'h1FFF};
        vt[8]  = '{2'b10, 14'h0000, 2'b00, 14'h0000, 1'b0, 1'b1, 1'b0, 8'd3, 14'h2000, 14'h1FFF};
        vt[9]  = '{2'b10, 14'h0000, 2'b01, 14'h3FFF, 1'b0, 1'b0, 1'b0, 8'd3, 14'h2000, 14'h1FFF};
        vt[10] = '{2'b10, 14'h0000, 2'b01, 14'h3FFF, 1'b0, 1'b0, 1'b0, 8'd3, 14'h2000, 14'h1FFF};
        vt[11] = '{2'b10, 14'h0000, 2'b01, 14'h3FFF, 1'b0, 1'b0, 1'b1, 8'd3, 14'h2000, 14'h1FFF};
        vt[12] = '{2'b10, 14'h0000, 2'b01, 14'h3FFF, 1'b1, 1'b0, 1'b1, 8'd3, 14'h0000, 14'h3FFF};

        rst_n = 1'b0;
        enable = 1'b0;
        serial_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_I", 32'(i_out), 32'h0);
        chk("rst_Q", 32'(q_out), 32'h0);
        chk_frame("rst", 1'b0, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b1;
        enable = 1'b1;

        // Lock acquisition, single miss, lock loss and re-lock
        for (int k = 0; k < 13; k++) begin
            if (vt[k].ev) sb.push_back({vt[k].i, vt[k].q});
            send_frame(vt[k].is, vt[k].i, vt[k].qs, vt[k].q);
            chk_frame($sformatf("vec%0d", k), vt[k].ev, vt[k].ee, vt[k].el, vt[k].ec);
            chk($sformatf("vec%0d_I", k), 32'(i_out), 32'(vt[k].ei));
            chk($sformatf("vec%0d_Q", k), 32'(q_out), 32'(vt[k].eq));
        end

        // Bit slip: one extra bit costs two bad boundaries and drops lock
        p0 = err_pulses;
        send_bit(1'b0);
        send_frame(2'b10, 14'h0000, 2'b01, 14'h3FFF);
        send_frame(2'b10, 14'h0000, 2'b01, 14'h3FFF);
        chk("slip_err_pulses", 32'(err_pulses - p0), 32'd2);
        chk("slip_locked", 32'(lock), 32'd0);
        chk("slip_err_count", 32'(ecnt), 32'd5);
        send_frame(2'b10, 14'h0000, 2'b01, 14'h3FFF);
        chk("slip_relock_f3", 32'(lock), 32'd0);
        send_frame(2'b10, 14'h0000, 2'b01, 14'h3FFF);
        chk("slip_relock_f4", 32'(lock), 32'd1);
        sb.push_back({14'h0000, 14'h3FFF});
        send_frame(2'b10, 14'h0000, 2'b01, 14'h3FFF);
        chk_frame("slip_f5", 1'b1, 1'b0, 1'b1, 8'd5);

        // Enable drop mid-frame holds I/Q and err_count
        send_bits({2'b10, 14'h1234, 2'b01, 14'h0567}, 16);
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk_frame("dis", 1'b0, 1'b0, 1'b0, 8'd5);
        chk("dis_I", 32'(i_out), 32'h0);
        chk("dis_Q", 32'(q_out), 32'h3FFF);
        enable = 1'b1;
        send_bits({2'b10, 14'h1234, 2'b01, 14'h0567}, 10);

        // Asynchronous reset mid-cycle clears every output immediately
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_I", 32'(i_out), 32'h0);
        chk("arst_Q", 32'(q_out), 32'h0);
        chk_frame("arst", 1'b0, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) sb.push_back({14'h0ABC, 14'h3F01});
            send_frame(2'b10, 14'h0ABC, 2'b01, 14'h3F01);
            chk_frame($sformatf("post_rst_f%0d", k), k == 4, 1'b0, k >= 3, 8'd0);
        end

        // Saturation on the instance that never drops lock
        for (int k = 1; k <= 300; k++) begin
            send_frame(2'b10, 14'h0000, 2'b00, 14'h0000);
            if (k == 254) chk("sat_254", 32'(s_ecnt), 32'hFE);
            if (k == 255) chk("sat_255", 32'(s_ecnt), 32'hFF);
        end
        chk("sat_300", 32'(s_ecnt), 32'hFF);
        chk("sat_locked", 32'(s_lock), 32'd1);
        chk("sat_sync_err", 32'(s_serr), 32'd1);
        chk("sat_valid", 32'(s_valid), 32'd0);
        chk("sat_I", 32'(si_out), 32'h0ABC);
        chk("sat_Q", 32'(sq_out), 32'h3F01);
        chk("main_after_sat_count", 32'(ecnt), 32'd2);
        chk("main_after_sat_locked", 32'(lock), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
